// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : mem_port_arbiter                                                 |
// | Shares one single-port memory between fetch and load/store, with          |
// | load/store priority, bounded fetch starvation and an access watchdog.     |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_LS_RUN = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy
);

    localparam int RUN_W = (MAX_LS_RUN < 1) ? 1 : $clog2(MAX_LS_RUN + 1);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [RUN_W-1:0] C_RUN_MAX = RUN_W'(MAX_LS_RUN);
    localparam logic [WD_W-1:0]  C_WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY_IF = 2'd1,
        S_BUSY_LS = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [RUN_W-1:0]  r_run_cnt;
    logic [WD_W-1:0]   r_wd_cnt;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_if_done;
    logic              r_ls_done;
    logic              r_err;
    logic              r_busy;

    logic w_grant_ls;
    logic w_grant_if;

    // Fetch wins a tie only once load/store has used up its run allowance.
    assign w_grant_ls = ls_req && (!if_req || (r_run_cnt != C_RUN_MAX));
    assign w_grant_if = if_req && !w_grant_ls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_run_cnt   <= '0;
            r_wd_cnt    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_ls_done   <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wd_cnt <= '0;
                    if (w_grant_ls) begin
                        r_state     <= S_BUSY_LS;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= ls_we;
                        r_mem_addr  <= ls_addr;
                        r_mem_wdata <= ls_wdata;
                        r_busy      <= 1'b1;
                        r_run_cnt   <= if_req ? (r_run_cnt + RUN_W'(1)) : '0;
                    end else if (w_grant_if) begin
                        r_state     <= S_BUSY_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_busy      <= 1'b1;
                        r_run_cnt   <= '0;
                    end
                end
                S_BUSY_IF, S_BUSY_LS: begin
                    r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    // A response in the watchdog's last cycle still counts as success.
                    if (mem_rdy || (r_wd_cnt == C_WD_LAST)) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err     <= !mem_rdy;
                        if (r_state == S_BUSY_IF) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= mem_rdy ? mem_rdata : '0;
                        end else begin
                            r_ls_done  <= 1'b1;
                            r_ls_rdata <= (mem_rdy && !r_mem_we) ? mem_rdata : '0;
                        end
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_if_done <= 1'b0;
                    r_ls_done <= 1'b0;
                    r_err     <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign if_done   = r_if_done;
    assign ls_done   = r_ls_done;
    assign err       = r_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_mem_port_arbiter                                              |
// | Directed self-checking bench for mem_port_arbiter.                        |
// | Rev    : 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdy;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_LS_RUN(2), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_rdata(ls_rdata), .ls_done(ls_done), .err(err), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    logic [31:0] exp_addr [6];
    logic        exp_is_ls [6];
    int          req_cycles;

    initial begin
        reset = 1'b0; if_req = 1'b1; if_addr = 32'h80;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0; mem_rdy = 1'b0;

        // Reset held for three cycles with a pending fetch
        step(); step(); step();
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_dones", {30'b0, if_done, ls_done}, 32'd0);
        chk("rst_err_busy", {30'b0, err, busy}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        reset = 1'b1;
        step();
        chk("post_rst_mem_req", {31'b0, mem_req}, 32'd1);
        chk("post_rst_mem_addr", mem_addr, 32'h80);
        chk("post_rst_busy", {31'b0, busy}, 32'd1);
        mem_rdy = 1'b1; mem_rdata = 32'h1111_1111;
        step();
        chk("post_rst_if_done", {31'b0, if_done}, 32'd1);
        if_req = 1'b0; mem_rdy = 1'b0;
        step();

        // Single fetch, two-cycle memory latency
        if_req = 1'b1; if_addr = 32'h40;
        step();
        chk("fetch_mem_req", {31'b0, mem_req}, 32'd1);
        chk("fetch_mem_addr", mem_addr, 32'h40);
        chk("fetch_mem_we_wdata", {31'b0, mem_we} | mem_wdata, 32'd0);
        step();
        chk("fetch_wait_done", {30'b0, if_done, ls_done}, 32'd0);
        mem_rdy = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        chk("fetch_if_done", {31'b0, if_done}, 32'd1);
        chk("fetch_if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("fetch_err", {31'b0, err}, 32'd0);
        chk("fetch_ls_done", {31'b0, ls_done}, 32'd0);
        chk("fetch_mem_req_drop", {31'b0, mem_req}, 32'd0);
        if_req = 1'b0; mem_rdy = 1'b0; mem_rdata = '0;
        step();
        chk("fetch_done_pulse", {31'b0, if_done}, 32'd0);
        chk("fetch_idle_busy", {31'b0, busy}, 32'd0);
        chk("fetch_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // Starvation bound: both requesting, single-cycle memory
        exp_addr  = '{32'h300, 32'h300, 32'h200, 32'h300, 32'h300, 32'h200};
        exp_is_ls = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        if_req = 1'b1; if_addr = 32'h200;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h300;
        mem_rdy = 1'b1; mem_rdata = 32'hAAAA_5555;
        for (int g = 0; g < 6; g++) begin
            step();
            chk($sformatf("starve_addr_%0d", g), mem_addr, exp_addr[g]);
            step();
            chk($sformatf("starve_done_%0d", g), {30'b0, if_done, ls_done},
                exp_is_ls[g] ? 32'd1 : 32'd2);
            step();
        end
        if_req = 1'b0; ls_req = 1'b0; mem_rdy = 1'b0;
        chk("starve_ls_rdata", ls_rdata, 32'hAAAA_5555);
        step();

        // Store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'h1234_5678;
        step();
        chk("store_mem_req", {31'b0, mem_req}, 32'd1);
        chk("store_mem_we", {31'b0, mem_we}, 32'd1);
        chk("store_mem_addr", mem_addr, 32'h100);
        chk("store_mem_wdata", mem_wdata, 32'h1234_5678);
        mem_rdy = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("store_ls_done", {31'b0, ls_done}, 32'd1);
        chk("store_ls_rdata", ls_rdata, 32'd0);
        chk("store_err", {31'b0, err}, 32'd0);
        ls_req = 1'b0; ls_we = 1'b0; mem_rdy = 1'b0;
        step();

        // Watchdog timeout on a load
        ls_req = 1'b1; ls_addr = 32'h500;
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_req) req_cycles++;
            if (ls_done) break;
        end
        chk("timeout_ls_done", {31'b0, ls_done}, 32'd1);
        chk("timeout_err", {31'b0, err}, 32'd1);
        chk("timeout_req_cycles", 32'(req_cycles), 32'd16);
        ls_req = 1'b0;
        step();
        chk("timeout_err_clear", {31'b0, err}, 32'd0);
        ls_req = 1'b1; ls_addr = 32'h504; mem_rdy = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        step();
        chk("after_to_ls_done", {31'b0, ls_done}, 32'd1);
        chk("after_to_err", {31'b0, err}, 32'd0);
        chk("after_to_ls_rdata", ls_rdata, 32'h0BAD_F00D);
        ls_req = 1'b0; mem_rdy = 1'b0;
        step();

        // Reset in the middle of a load/store access
        ls_req = 1'b1; ls_addr = 32'h600; if_req = 1'b1; if_addr = 32'h700;
        step();
        chk("midrst_grant_addr", mem_addr, 32'h600);
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_async_req", {31'b0, mem_req}, 32'd0);
        chk("midrst_async_busy", {31'b0, busy}, 32'd0);
        ls_req = 1'b0;
        step();
        chk("midrst_no_done", {30'b0, if_done, ls_done}, 32'd0);
        reset = 1'b1;
        step();
        chk("midrst_if_grant", {31'b0, mem_req}, 32'd1);
        chk("midrst_if_addr", mem_addr, 32'h700);
        mem_rdy = 1'b1; mem_rdata = 32'h0000_0077;
        step();
        chk("midrst_if_done", {30'b0, if_done, ls_done}, 32'd2);
        chk("midrst_if_rdata", if_rdata, 32'h0000_0077);
        if_req = 1'b0; mem_rdy = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
